// File: rtl/dc_onehot_fifo_buffer.sv
// dc_onehot_fifo_buffer
//   Single-clock FIFO that owns its storage and its one-hot write/read ring
//   pointers. Both sides use valid/ready handshakes. Read data is first-word
//   fall-through: the head entry is always visible on out_data.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset (clears storage and state)
//   flush         synchronous flush; empties the buffer, storage untouched
//   in_valid      write request
//   in_ready      buffer not full (combinational from state)
//   in_data       write data
//   out_valid     buffer not empty (combinational from state)
//   out_ready     consumer accepts the head entry
//   out_data      head entry, AND-OR mux over read_pointer
//   write_pointer one-hot slot for the next write
//   read_pointer  one-hot slot of the head entry
//   count         occupancy, 0..BUFFER_DEPTH
//   ptr_error     sticky: a pointer was seen not one-hot (cleared by rst only)
module dc_onehot_fifo_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int CNT_WIDTH    = $clog2(BUFFER_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [BUFFER_DEPTH-1:0] write_pointer,
    output logic [BUFFER_DEPTH-1:0] read_pointer,
    output logic [CNT_WIDTH-1:0]    count,
    output logic                    ptr_error
);

    localparam logic [BUFFER_DEPTH-1:0] PTR_INIT  = BUFFER_DEPTH'(1'b1);
    localparam logic [BUFFER_DEPTH-1:0] PTR_ZERO  = {BUFFER_DEPTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]    CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE   = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0]    CNT_FULL  = CNT_WIDTH'(BUFFER_DEPTH);
    localparam logic [DATA_WIDTH-1:0]   DATA_ZERO = {DATA_WIDTH{1'b0}};

    // True when exactly one bit is set: non-zero and clearing the lowest
    // set bit leaves nothing behind.
    function automatic logic is_onehot(input logic [BUFFER_DEPTH-1:0] vec);
        return (vec != PTR_ZERO) && ((vec & (vec - PTR_INIT)) == PTR_ZERO);
    endfunction

    // Advance a ring pointer by one slot; the top bit wraps to bit 0.
    function automatic logic [BUFFER_DEPTH-1:0] rotate_left(input logic [BUFFER_DEPTH-1:0] vec);
        return {vec[BUFFER_DEPTH-2:0], vec[BUFFER_DEPTH-1]};
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [BUFFER_DEPTH];
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [DATA_WIDTH-1:0] head_s;

    // Status decode and handshake qualification. Flush suppresses both
    // transfers but deliberately does not mask in_ready.
    always_comb begin
        full_s    = (count == CNT_FULL);
        empty_s   = (count == CNT_ZERO);
        in_ready  = !full_s;
        out_valid = !empty_s;
        push_s    = in_valid && !full_s && !flush;
        pop_s     = out_ready && !empty_s && !flush;
    end

    // Head-entry mux: each slot is gated by its read_pointer bit and the
    // results are OR-ed, so no index encoder sits in the read path.
    always_comb begin
        head_s = DATA_ZERO;
        for (int i = 0; i < BUFFER_DEPTH; i++) begin
            head_s = head_s | (mem_r[i] & {DATA_WIDTH{read_pointer[i]}});
        end
        out_data = head_s;
    end

    // Storage: the slot selected by write_pointer captures in_data on a push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                mem_r[i] <= DATA_ZERO;
            end
        end else begin
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                if (push_s && write_pointer[i]) begin
                    mem_r[i] <= in_data;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    // Pointers and occupancy. Flush returns to the empty state but leaves
    // storage contents in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_pointer <= PTR_INIT;
            read_pointer  <= PTR_INIT;
            count         <= CNT_ZERO;
        end else if (flush) begin
            write_pointer <= PTR_INIT;
            read_pointer  <= PTR_INIT;
            count         <= CNT_ZERO;
        end else begin
            if (push_s) begin
                write_pointer <= rotate_left(write_pointer);
            end else begin
                write_pointer <= write_pointer;
            end
            if (pop_s) begin
                read_pointer <= rotate_left(read_pointer);
            end else begin
                read_pointer <= read_pointer;
            end
            case ({push_s, pop_s})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky pointer-integrity flag for fault/SEU detection. Flush does not
    // clear it; only rst does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_error <= 1'b0;
        end else if (!is_onehot(write_pointer) || !is_onehot(read_pointer)) begin
            ptr_error <= 1'b1;
        end else begin
            ptr_error <= ptr_error;
        end
    end

endmodule
